// File: rtl/vector_addsub_tiled_pkg.sv
// Shared definitions for the tiled vector add/subtract block.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package vector_addsub_pkg;

    localparam logic [1:0] MODE_ADD     = 2'b00;
    localparam logic [1:0] MODE_A_SUB_B = 2'b01;
    localparam logic [1:0] MODE_B_SUB_A = 2'b10;
    localparam logic [1:0] MODE_PASS_A  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of chunks needed to cover x elements at y lanes per chunk.
    function automatic int ceil_div(input int x, input int y);
        return (x + y - 1) / y;
    endfunction

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter wide enough to hold the values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vector_addsub_tiled_if.sv
// Request/result bundle for vector_addsub_tiled.
// Latency: n/a (wires only).
// Backpressure: none; start is sampled only while the block is idle.
// Ports: start/mode/a/b from the requester, result/valid/busy/overflow back.
interface vector_addsub_tiled_if #(
    parameter int VECTOR_LEN        = 5,
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 8
);
    logic                                    start;
    logic [1:0]                              mode;
    logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a;
    logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b;
    logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result;
    logic                                    valid;
    logic                                    busy;
    logic                                    overflow;

    modport master (
        output start, mode, a, b,
        input  result, valid, busy, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output result, valid, busy, overflow
    );
endinterface

// File: rtl/vector_addsub_tiled_addsub_lane.sv
// One lane: exact add/sub of a sign-extended cell pair, narrowed to R bits.
// Latency: combinational.
// Backpressure: none; en masks the overflow report of an idle lane.
// Ports: a_cell, b_cell, mode, en in; res (R bits), ovf out.
// Build option: VECTOR_ADDSUB_SATURATE_EN clamps overflowing results instead of wrapping.
module addsub_lane
    import vector_addsub_pkg::*;
#(
    parameter int A_W = 8,
    parameter int B_W = 8,
    parameter int R_W = 8
) (
    input  logic signed [A_W-1:0] a_cell,
    input  logic signed [B_W-1:0] b_cell,
    input  logic [1:0]            mode,
    input  logic                  en,
    output logic [R_W-1:0]        res,
    output logic                  ovf
);
    // One guard bit above the widest operand makes every mode exact.
    localparam int W = max(A_W, B_W) + 1;

    logic signed [W-1:0] ax;
    logic signed [W-1:0] bx;
    logic signed [W-1:0] exact;
    logic                ovf_raw;

    assign ax = W'(a_cell);
    assign bx = W'(b_cell);

    always_comb begin
        exact = ax;
        case (mode)
            MODE_ADD:     exact = ax + bx;
            MODE_A_SUB_B: exact = ax - bx;
            MODE_B_SUB_A: exact = bx - ax;
            default:      exact = ax;
        endcase
    end

    generate
        if (R_W >= W) begin : g_wide
            // Every exact value fits; just sign-extend.
            assign res     = R_W'(exact);
            assign ovf_raw = 1'b0;
        end else begin : g_narrow
            logic [R_W-1:0]      low;
            logic signed [W-1:0] back;

            assign low = exact[R_W-1:0];
            // Out of range exactly when the low bits do not sign-extend back.
            assign back    = W'(signed'(low));
            assign ovf_raw = (back != exact);
`ifdef VECTOR_ADDSUB_SATURATE_EN
            assign res = !ovf_raw ? low :
                         exact[W-1] ? {1'b1, {(R_W-1){1'b0}}}
                                    : {1'b0, {(R_W-1){1'b1}}};
`else
            assign res = low;
`endif
        end
    endgenerate

    assign ovf = en & ovf_raw;

endmodule

// File: rtl/vector_addsub_tiled.sv
// Element-wise a+b / a-b / b-a / pass-a over a vector, TILING lanes per clock.
// Latency: ceil(VECTOR_LEN/TILING) cycles from accepted start to the valid pulse.
// Backpressure: none; start is ignored while busy, accepted again in the valid cycle.
// Ports: clk, rst (async, active high), bus (slave side of vector_addsub_tiled_if).
// Build option: VECTOR_ADDSUB_SATURATE_EN selects saturating lanes (default wraps).
module vector_addsub_tiled
    import vector_addsub_pkg::*;
#(
    parameter int VECTOR_LEN        = 5,
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int TILING            = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    vector_addsub_tiled_if.slave   bus
);
    localparam int N  = ceil_div(VECTOR_LEN, TILING);
    localparam int CW = cnt_width(N);
    // Element index can reach N*TILING-1 in the last chunk.
    localparam int IW = cnt_width(N * TILING);
    localparam int AW = A_CELL_WIDTH;
    localparam int BW = B_CELL_WIDTH;
    localparam int RW = RESULT_CELL_WIDTH;

    state_t                  state;
    state_t                  state_n;
    logic [CW-1:0]           cnt;
    logic [VECTOR_LEN*AW-1:0] a_q;
    logic [VECTOR_LEN*BW-1:0] b_q;
    logic [1:0]              mode_q;
    logic [VECTOR_LEN*RW-1:0] result_q;
    logic                    valid_q;
    logic                    ovf_q;
    logic                    last_chunk;

    logic [IW-1:0]           lane_idx [TILING];
    logic [TILING-1:0]       lane_en;
    logic [TILING-1:0]       lane_ovf;
    logic [RW-1:0]           lane_res [TILING];

    assign last_chunk = (cnt == CW'(N - 1));

    generate
        for (genvar j = 0; j < TILING; j++) begin : g_lane
            logic signed [AW-1:0] a_sel;
            logic signed [BW-1:0] b_sel;

            // Lanes whose index runs past the vector end are masked.
            always_comb begin
                lane_idx[j] = IW'(cnt) * IW'(TILING) + IW'(j);
                lane_en[j]  = (state == ST_RUN) && (lane_idx[j] < IW'(VECTOR_LEN));
            end

            always_comb begin
                a_sel = '0;
                b_sel = '0;
                for (int e = 0; e < VECTOR_LEN; e++) begin
                    if (lane_idx[j] == IW'(e)) begin
                        a_sel = a_q[e*AW +: AW];
                        b_sel = b_q[e*BW +: BW];
                    end
                end
            end

            addsub_lane #(
                .A_W (AW),
                .B_W (BW),
                .R_W (RW)
            ) u_lane (
                .a_cell (a_sel),
                .b_cell (b_sel),
                .mode   (mode_q),
                .en     (lane_en[j]),
                .res    (lane_res[j]),
                .ovf    (lane_ovf[j])
            );
        end
    endgenerate

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (bus.start) state_n = ST_RUN;
            ST_RUN:  if (last_chunk) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state   <= state_n;
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        mode_q <= bus.mode;
                        cnt    <= '0;
                        ovf_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cnt   <= cnt + 1'b1;
                    ovf_q <= ovf_q | (|lane_ovf);
                    for (int j = 0; j < TILING; j++) begin
                        for (int e = 0; e < VECTOR_LEN; e++) begin
                            if (lane_en[j] && (lane_idx[j] == IW'(e))) begin
                                result_q[e*RW +: RW] <= lane_res[j];
                            end
                        end
                    end
                    if (last_chunk) valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = (state == ST_RUN);
    assign bus.overflow = ovf_q;

endmodule
